carry_save_resolve: RTL and testbench

- Converts a carry-save pair (sum vector plus carry vector) into a conventional binary result.
- Uses one K-bit chunked ripple addition per cycle, so no full-width carry chain is needed.
- Sits downstream of the carry-save adder/accumulator arrays in the FixedPointArithmetic IP and is the reader end of the redundant-form datapath.
- Uses valid/ready handshakes on input and output.

---
 rtl/carry_save_resolve.sv | 140 ++++++++++++++
 tb/tb_carry_save_resolve.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/carry_save_resolve.sv
// carry_save_resolve: resolves a carry-save pair (s, cv, ci) into binary c/co.
// The default build adds one K-bit chunk per cycle, so no full-width carry chain
// is needed. Defining CARRY_SAVE_RESOLVE_SINGLE_CYCLE_EN replaces this with one
// full-width addition on the accept edge, and BUSY is then never entered.
// valid/ready handshakes on both sides; in_ready/out_valid decode state only.
module carry_save_resolve #(
    parameter int N = 32,
    parameter int K = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] s,
    input  logic [N-1:0] cv,
    input  logic         ci,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         co
);

    localparam int NC = N / K;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_nx;
    logic   last_chunk;

    // State register; reset abandons any in-flight resolution
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state and handshake decode (outputs depend on state only)
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
`ifdef CARRY_SAVE_RESOLVE_SINGLE_CYCLE_EN
                if (in_valid) state_nx = DONE;
`else
                if (in_valid) state_nx = BUSY;
`endif
            end
            BUSY: begin
                if (last_chunk) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef CARRY_SAVE_RESOLVE_SINGLE_CYCLE_EN

    logic [N:0] full_sum;

    assign last_chunk = 1'b1;

    // Full-width resolution of the live inputs for the accept edge
    always_comb begin
        full_sum = {1'b0, s} + {1'b0, cv} + {{N{1'b0}}, ci};
    end

    // Result register: written only on the accept edge, held otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c  <= '0;
            co <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            {co, c} <= full_sum;
        end
    end

`else

    localparam int JW = (NC > 1) ? $clog2(NC) : 1;
    localparam logic [JW-1:0] JLAST = JW'(NC - 1);

    logic [JW-1:0] j;
    logic          carry;
    logic [N-1:0]  s_p0;
    logic [N-1:0]  cv_p0;
    logic [K:0]    chunk_sum;

    assign last_chunk = (j == JLAST);

    // One K-bit slice of the addition, chained through the running carry
    always_comb begin
        chunk_sum = {1'b0, s_p0[j*K +: K]} + {1'b0, cv_p0[j*K +: K]} + {{K{1'b0}}, carry};
    end

    // Operand capture on the accept edge; later input changes are ignored
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            s_p0  <= s;
            cv_p0 <= cv;
        end
    end

    // Chunk walker: seeds carry from ci, then writes one slice of c per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c     <= '0;
            co    <= 1'b0;
            j     <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        carry <= ci;
                        j     <= '0;
                    end
                end
                BUSY: begin
                    c[j*K +: K] <= chunk_sum[K-1:0];
                    carry       <= chunk_sum[K];
                    if (last_chunk) begin
                        co <= chunk_sum[K];
                        j  <= '0;
                    end else begin
                        j  <= j + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_carry_save_resolve.sv
// Testbench for carry_save_resolve: directed scenarios plus a random
// back-to-back stream; a queue scoreboard is drained by a monitor process.
module tb_carry_save_resolve;

    localparam int N = 32;
    localparam int K = 8;
`ifdef CARRY_SAVE_RESOLVE_SINGLE_CYCLE_EN
    localparam int LAT = 0;      // edges after the accept edge until out_valid is seen
`else
    localparam int LAT = N / K;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] s;
    logic [N-1:0] cv;
    logic         ci;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] c;
    logic         co;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [N:0] sb[$];
    logic [N:0] mon_exp;

    carry_save_resolve #(.N(N), .K(K)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .cv(cv), .ci(ci),
        .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .co(co)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [N:0] ref_sum(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic cin);
        return {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every output transfer must match the oldest expected result
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("mon_unexpected_output", 64'(out_valid), 64'(0));
            end else begin
                mon_exp = sb.pop_front();
                chk("mon_c", 64'(c), 64'(mon_exp[N-1:0]));
                chk("mon_co", 64'(co), 64'(mon_exp[N]));
            end
        end
    end

    task automatic accept(input logic [N-1:0] ts, input logic [N-1:0] tcv, input logic tci,
                          output bit ok);
        int w = 0;
        ok = 1'b0;
        while (in_ready !== 1'b1 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (in_ready !== 1'b1) begin
            chk("accept_timeout", 64'(in_ready), 64'(1));
            return;
        end
        s = ts; cv = tcv; ci = tci; in_valid = 1'b1;
        sb.push_back(ref_sum(ts, tcv, tci));
        @(posedge clk); #1;
        in_valid = 1'b0;
        s = $urandom; cv = $urandom; ci = 1'($urandom_range(0, 1));
        ok = 1'b1;
    endtask

    // Walks from the accept edge to the first cycle with out_valid high
    task automatic wait_done(input string tag);
        chk({tag, "_ready_low"}, 64'(in_ready), 64'(0));
        chk({tag, "_valid_e0"}, 64'(out_valid), 64'(LAT == 0));
        for (int i = 1; i <= LAT; i++) begin
            @(posedge clk); #1;
            chk({tag, "_valid_lat"}, 64'(out_valid), 64'(i == LAT));
            chk({tag, "_ready_lat"}, 64'(in_ready), 64'(0));
        end
    endtask

    initial begin
        logic [N:0]   exp;
        logic [N-1:0] hs;
        logic [N-1:0] hcv;
        logic         hci;
        bit           ok;
        int           got;
        int           last;
        int           guard;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        s = '0; cv = '0; ci = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_c", 64'(c), 64'(0));
        chk("rst_co", 64'(co), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        // Overflow: all-ones plus one wraps to zero with carry out
        accept(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, ok);
        if (ok) begin
            wait_done("t1");
            chk("t1_c", 64'(c), 64'h0);
            chk("t1_co", 64'(co), 64'(1));
            @(posedge clk); #1;
        end

        // Carry-in propagation, and result held after the transfer
        accept(32'h1234_5678, 32'h1111_1111, 1'b1, ok);
        if (ok) begin
            wait_done("t2");
            chk("t2_c", 64'(c), 64'h2345_678A);
            chk("t2_co", 64'(co), 64'(0));
            @(posedge clk); #1;
            chk("t2_ready_after", 64'(in_ready), 64'(1));
            chk("t2_c_held", 64'(c), 64'h2345_678A);
        end

        // Backpressure in DONE with ignored in_valid pulses
        out_ready = 1'b0;
        hs = $urandom; hcv = $urandom; hci = 1'($urandom_range(0, 1));
        exp = ref_sum(hs, hcv, hci);
        accept(hs, hcv, hci, ok);
        if (ok) begin
            wait_done("bp");
            for (int i = 0; i < 5; i++) begin
                in_valid = 1'b1;
                s = $urandom; cv = $urandom; ci = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                chk("bp_valid", 64'(out_valid), 64'(1));
                chk("bp_ready", 64'(in_ready), 64'(0));
                chk("bp_c", 64'(c), 64'(exp[N-1:0]));
                chk("bp_co", 64'(co), 64'(exp[N]));
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            @(posedge clk); #1;
            chk("bp_valid_after", 64'(out_valid), 64'(0));
            chk("bp_ready_after", 64'(in_ready), 64'(1));
            chk("bp_c_held", 64'(c), 64'(exp[N-1:0]));
        end

        // Reset two cycles into an operation discards it
        out_ready = 1'b0;
        accept($urandom, $urandom, 1'b1, ok);
        if (ok) begin
            repeat (2) begin @(posedge clk); #1; end
            rst = 1'b1;
            #1;
            chk("mid_rst_valid", 64'(out_valid), 64'(0));
            chk("mid_rst_c", 64'(c), 64'(0));
            chk("mid_rst_co", 64'(co), 64'(0));
            void'(sb.pop_back());
            @(posedge clk); #1;
            rst = 1'b0;
            out_ready = 1'b1;
            #1;
            chk("mid_rst_ready", 64'(in_ready), 64'(1));
        end
        out_ready = 1'b1;
        accept(32'h0000_0005, 32'h0000_0003, 1'b0, ok);
        if (ok) begin
            wait_done("t4");
            chk("t4_c", 64'(c), 64'h8);
            chk("t4_co", 64'(co), 64'(0));
            @(posedge clk); #1;
        end

        // Back-to-back random stream; spacing = accept + LAT edges + transfer edge
        got = 0; last = -1; guard = 0;
        s = $urandom; cv = $urandom; ci = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        while (got < 16 && guard < 400) begin
            guard++;
            if (in_ready === 1'b1) begin
                sb.push_back(ref_sum(s, cv, ci));
                @(posedge clk); #1;
                if (last >= 0) chk("b2b_spacing", 64'(cyc - last), 64'(LAT + 2));
                last = cyc;
                got++;
                s = $urandom; cv = $urandom; ci = 1'($urandom_range(0, 1));
            end else begin
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        chk("b2b_count", 64'(got), 64'(16));

        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
